// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter.
// Merges the in-order pipeline writeback (top priority, no backpressure) with
// a long-latency result stream (valid/ready) into one registered write per
// cycle. Long-latency results that lose arbitration wait in a small in-order
// FIFO. A pipeline write kills any queued long-latency write to the same
// register so the younger value always wins (WAW).
module rf_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pipe_we,
  input  logic [AW-1:0]            pipe_waddr,
  input  logic [DW-1:0]            pipe_wdata,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [AW-1:0]            lu_waddr,
  input  logic [DW-1:0]            lu_wdata,
  output logic                     we,
  output logic [AW-1:0]            waddr,
  output logic [DW-1:0]            wdata,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // FIFO storage: address/data are pure data, live bits and pointers are control
  logic [AW-1:0]    q_addr [DEPTH];
  logic [DW-1:0]    q_data [DEPTH];
  logic [DEPTH-1:0] q_live;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  // Stage 0 decisions (combinational, feed the output register)
  logic          accept_p0;
  logic          pipe_hit_p0;
  logic          fifo_empty_p0;
  logic          sel_we_p0;
  logic [AW-1:0] sel_addr_p0;
  logic [DW-1:0] sel_data_p0;
  logic          push_p0;
  logic          push_live_p0;
  logic          pop_p0;
  logic          cancel_p0;

  // Ready depends only on registered occupancy (and reset), never on inputs
  assign lu_ready = !reset && (fifo_count < FULL);

  // Priority selection: pipeline write, then FIFO head, then bypass, else idle
  always_comb begin
    accept_p0     = lu_valid && lu_ready;
    pipe_hit_p0   = pipe_we && (pipe_waddr != '0);
    fifo_empty_p0 = (fifo_count == '0);
    sel_we_p0     = 1'b0;
    sel_addr_p0   = pipe_waddr;
    sel_data_p0   = pipe_wdata;
    push_p0       = 1'b0;
    push_live_p0  = 1'b1;
    pop_p0        = 1'b0;
    cancel_p0     = 1'b0;
    if (pipe_hit_p0) begin
      sel_we_p0    = 1'b1;
      cancel_p0    = 1'b1;
      // x0 results are dropped at the door; same-address results arrive dead
      push_p0      = accept_p0 && (lu_waddr != '0);
      push_live_p0 = (lu_waddr != pipe_waddr);
    end else if (!fifo_empty_p0) begin
      pop_p0      = 1'b1;
      sel_we_p0   = q_live[rd_ptr];
      sel_addr_p0 = q_addr[rd_ptr];
      sel_data_p0 = q_data[rd_ptr];
      push_p0     = accept_p0 && (lu_waddr != '0);
    end else if (accept_p0 && (lu_waddr != '0)) begin
      sel_we_p0   = 1'b1;
      sel_addr_p0 = lu_waddr;
      sel_data_p0 = lu_wdata;
    end
  end

  // ---- stage 0 -> stage 1 boundary: output register and FIFO control ----
  // Output write port and FIFO bookkeeping; cancelled pops free the slot silently
  always_ff @(posedge clock) begin
    if (reset) begin
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      q_live     <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      we <= sel_we_p0;
      if (sel_we_p0) begin
        waddr <= sel_addr_p0;
        wdata <= sel_data_p0;
      end
      if (cancel_p0) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (q_addr[i] == pipe_waddr) q_live[i] <= 1'b0;
        end
      end
      if (push_p0) begin
        q_live[wr_ptr] <= push_live_p0;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop_p0) rd_ptr <= rd_ptr + 1'b1;
      case ({push_p0, pop_p0})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO payload storage; no reset needed since live bits gate every use
  always_ff @(posedge clock) begin
    if (push_p0) begin
      q_addr[wr_ptr] <= lu_waddr;
      q_data[wr_ptr] <= lu_wdata;
    end
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Producer end of the register file's single write port (we/waddr/wdata).
- Merges two writeback sources into one registered write per cycle:
  - the in-order pipeline WB stage: highest priority, no backpressure;
  - a long-latency unit (mul/div/load-miss) over a valid/ready handshake.
- Long-latency results that lose arbitration are held in a small FIFO.
- WAW ordering is enforced: a younger pipeline write cancels any queued older long-latency write to the same register.

Parameters:
DEPTH  4  FIFO entries for long-latency results; power of 2, >=2
AW  5  register address width
DW  32  data width

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
pipe_we  in  1  pipeline WB write request
pipe_waddr  in  AW  pipeline WB destination
pipe_wdata  in  DW  pipeline WB data
lu_valid  in  1  long-latency result valid
lu_ready  out  1  arbiter can accept a long-latency result
lu_waddr  in  AW  long-latency destination
lu_wdata  in  DW  long-latency data
we  out  1  regfile write enable (registered)
waddr  out  AW  regfile write address (registered)
wdata  out  DW  regfile write data (registered)
fifo_count  out  log2(DEPTH)+1  occupied FIFO slots, live or cancelled

Behaviour:
- Reset (synchronous, active-high clock/reset as already decided):
  - we=0, waddr=0, wdata=0;
  - FIFO empty, fifo_count=0, all entry live bits cleared;
  - lu_ready=0 while reset is high.
  - Reset mid-operation discards all queued entries. No write is issued in the cycle after reset is sampled.
- lu_ready = !reset && (fifo_count < DEPTH).
  - Purely from registered state; never depends on lu_valid or pipe_we.
  - No push-when-full, even if a pop occurs in the same cycle.
- Handshake:
  - A result is accepted when lu_valid && lu_ready at a rising edge.
  - The source must hold lu_waddr/lu_wdata stable while valid && !ready.
- Zero register:
  - A write to address 0 from either source is accepted but never produces we=1.
  - lu entries to x0 are consumed without occupying a FIFO slot.
- Per-cycle selection, evaluated in priority order; the output register loads at the next edge (1-cycle latency):
  1. pipe_we && pipe_waddr!=0 -> write pipe_waddr/pipe_wdata. Any accepted lu result this cycle is pushed.
  2. else FIFO non-empty -> pop head. If the head is live, write its addr/data; if cancelled, we=0 and the slot is freed. Any accepted lu result is pushed.
  3. else an lu result accepted this cycle with FIFO empty -> bypass straight to the output (we=1 next cycle); nothing is pushed.
  4. else we=0. waddr/wdata hold their previous values.
- Cancellation (WAW):
  - When case 1 fires with address A, every FIFO entry with waddr==A has its live bit cleared.
  - An lu result accepted in the same cycle with lu_waddr==A is pushed already cancelled.
  - The pipeline is always younger than any outstanding long-latency result.
- Ordering:
  - FIFO is strictly in order; pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave fifo_count unchanged.
- Throughput:
  - One regfile write per cycle maximum.
  - Under continuous pipe writes the FIFO does not drain; lu backpressure via lu_ready is the only relief.
- Outputs we/waddr/wdata are glitch-free registers. fifo_count is registered.

Test Plan:
- Reset then idle -> we=0, waddr=0, wdata=0, lu_ready=1 after reset drops, fifo_count=0.
- pipe_we=1, pipe_waddr=5, pipe_wdata=0x11223344 at cycle N -> cycle N+1: we=1, waddr=5, wdata=0x11223344; cycle N+2: we=0.
- FIFO empty, no pipe write, lu accept (waddr=7, wdata=0xDEADBEEF) -> next cycle we=1, waddr=7, fifo_count stays 0.
- Continuous pipe writes to r1 for 6 cycles while lu offers r2..r6:
  - 4 accepted, fifo_count=4, lu_ready=0;
  - after pipe stops, r2..r5 are written in order on 4 consecutive cycles;
  - r6 is then accepted.
- Queue lu write r9=0xAAAA, then pipe write r9=0xBBBB before it drains -> only one write to r9 (0xBBBB); the cancelled slot drains with we=0 and fifo_count decrements.
- pipe write r0 and lu write r0 -> we never asserts.
- Assert reset with fifo_count=3 -> next cycle fifo_count=0, we=0, and no queued entry is ever written.
